// File: rtl/vid_framer.sv
// Frames an unframed pixel stream into AXI4-Stream video (tuser = SOF, tlast = EOL).
// Geometry is latched at frame start; the output side is a 2-entry skid buffer.
module vid_framer #(
    parameter int PIXEL_W = 8,
    parameter int MAX_W   = 2048,
    parameter int MAX_H   = 2048,
    localparam int COL_W  = $clog2(MAX_W + 1),
    localparam int ROW_W  = $clog2(MAX_H + 1)
) (
    input  logic               clk_i,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [COL_W-1:0]   width_i,
    input  logic [ROW_W-1:0]   height_i,
    output logic               busy_o,
    output logic               err_o,
    output logic               frame_done_o,
    input  logic               s_tvalid_i,
    input  logic [PIXEL_W-1:0] s_tdata_i,
    output logic               s_tready_o,
    output logic               m_tvalid_o,
    output logic [PIXEL_W-1:0] m_tdata_o,
    output logic               m_tuser_o,
    output logic               m_tlast_o,
    input  logic               m_tready_i
);

    localparam int ENT_W = PIXEL_W + 2;

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [COL_W-1:0]   w_q, col_q;
    logic [ROW_W-1:0]   h_q, row_q;
    logic [1:0]         cnt_q, cnt_d;
    logic               wr_ptr_q, rd_ptr_q;
    logic               s_tready_q;
    logic               err_q, done_q;
    logic [ENT_W-1:0]   skid_p1 [2];

    logic               in_hs, pop, vld_p1;
    logic               col_last, row_last, tuser_p0, final_beat, start_ok;

    function automatic logic geom_ok(input logic [COL_W-1:0] w, input logic [ROW_W-1:0] h);
        return (w != '0) && (w <= COL_W'(MAX_W)) && (h != '0) && (h <= ROW_W'(MAX_H));
    endfunction

    assign in_hs      = s_tvalid_i && s_tready_q;
    assign vld_p1     = (cnt_q != 2'd0);
    assign pop        = vld_p1 && m_tready_i;
    assign col_last   = (col_q == w_q - COL_W'(1));
    assign row_last   = (row_q == h_q - ROW_W'(1));
    assign tuser_p0   = (col_q == '0) && (row_q == '0);
    // In DRAIN nothing is pushed, so the sole remaining entry is the frame's last pixel.
    assign final_beat = (state_q == DRAIN) && pop && (cnt_q == 2'd1);
    assign start_ok   = (state_q == IDLE) && start_i && geom_ok(width_i, height_i);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (in_hs && !pop)
            cnt_d = cnt_q + 2'd1;
        else if (!in_hs && pop)
            cnt_d = cnt_q - 2'd1;
        case (state_q)
            IDLE:    if (start_ok) state_d = ACTIVE;
            ACTIVE:  if (in_hs && col_last && row_last) state_d = DRAIN;
            DRAIN:   if (final_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            s_tready_q <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            w_q        <= '0;
            h_q        <= '0;
            col_q      <= '0;
            row_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            // Ready is registered from the next occupancy, so a high ready always has a free slot.
            s_tready_q <= (state_d == ACTIVE) && (cnt_d != 2'd2);
            err_q      <= (state_q == IDLE) && start_i && !geom_ok(width_i, height_i);
            done_q     <= final_beat;
            if (in_hs)
                wr_ptr_q <= ~wr_ptr_q;
            if (pop)
                rd_ptr_q <= ~rd_ptr_q;
            if (start_ok) begin
                w_q   <= width_i;
                h_q   <= height_i;
                col_q <= '0;
                row_q <= '0;
            end else if (in_hs) begin
                if (col_last) begin
                    col_q <= '0;
                    row_q <= row_last ? '0 : row_q + ROW_W'(1);
                end else begin
                    col_q <= col_q + COL_W'(1);
                end
            end
        end
    end

    // p0 -> p1: tagged pixel enters the skid buffer
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            skid_p1[0] <= '0;
            skid_p1[1] <= '0;
        end else if (in_hs) begin
            skid_p1[wr_ptr_q] <= {tuser_p0, col_last, s_tdata_i};
        end
    end

    assign {m_tuser_o, m_tlast_o, m_tdata_o} = skid_p1[rd_ptr_q];
    assign m_tvalid_o   = vld_p1;
    assign s_tready_o   = s_tready_q;
    assign busy_o       = (state_q != IDLE);
    assign err_o        = err_q;
    assign frame_done_o = done_q;

endmodule

// File: tb/tb_vid_framer.sv
// Directed bench for vid_framer: frame tagging, stalls, geometry errors, mid-frame start and reset.
module tb_vid_framer;

    localparam int PIXEL_W = 8;
    localparam int MAX_W   = 2048;
    localparam int MAX_H   = 2048;
    localparam int COL_W   = $clog2(MAX_W + 1);
    localparam int ROW_W   = $clog2(MAX_H + 1);

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start_i;
    logic [COL_W-1:0]   width_i;
    logic [ROW_W-1:0]   height_i;
    logic               busy_o, err_o, frame_done_o;
    logic               s_tvalid_i;
    logic [PIXEL_W-1:0] s_tdata_i;
    logic               s_tready_o;
    logic               m_tvalid_o;
    logic [PIXEL_W-1:0] m_tdata_o;
    logic               m_tuser_o, m_tlast_o;
    logic               m_tready_i;

    vid_framer #(.PIXEL_W(PIXEL_W), .MAX_W(MAX_W), .MAX_H(MAX_H)) dut (
        .clk_i(clk), .rst_n(rst_n), .start_i(start_i), .width_i(width_i), .height_i(height_i),
        .busy_o(busy_o), .err_o(err_o), .frame_done_o(frame_done_o),
        .s_tvalid_i(s_tvalid_i), .s_tdata_i(s_tdata_i), .s_tready_o(s_tready_o),
        .m_tvalid_o(m_tvalid_o), .m_tdata_o(m_tdata_o), .m_tuser_o(m_tuser_o),
        .m_tlast_o(m_tlast_o), .m_tready_i(m_tready_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    logic [9:0] beat_q[$];
    int         beat_cyc_q[$];
    int         acc_cyc_q[$];
    logic       prev_stall = 1'b0;
    logic [9:0] prev_beat = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", 32'({m_tvalid_o, m_tuser_o, m_tlast_o, m_tdata_o}),
                      32'({1'b1, prev_beat}));
            if (m_tvalid_o && m_tready_i) begin
                beat_q.push_back({m_tuser_o, m_tlast_o, m_tdata_o});
                beat_cyc_q.push_back(cyc);
            end
            prev_stall = m_tvalid_o && !m_tready_i;
            prev_beat  = {m_tuser_o, m_tlast_o, m_tdata_o};
            if (frame_done_o) done_cnt++;
            if (err_o) err_cnt++;
        end
    end

    task automatic clear_q();
        beat_q.delete();
        beat_cyc_q.delete();
        acc_cyc_q.delete();
    endtask

    task automatic do_start(input int w, input int h);
        start_i  = 1'b1;
        width_i  = COL_W'(w);
        height_i = ROW_W'(h);
        @(posedge clk); #1;
        start_i  = 1'b0;
    endtask

    task automatic drive_pixels(input int npix, input int base, input bit gaps, input bit toggle,
                                input int mid_start);
        int i = 0;
        int budget = 0;
        bit hs;
        bit mid_done = 1'b0;
        logic r0;
        while (i < npix && budget < 400) begin
            s_tvalid_i = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            s_tdata_i  = 8'(base + i);
            m_tready_i = toggle ? ~m_tready_i : 1'b1;
            start_i    = 1'b0;
            if (i == mid_start && !mid_done) begin
                start_i  = 1'b1;
                width_i  = COL_W'(8);
                height_i = ROW_W'(2);
                mid_done = 1'b1;
            end
            if (toggle) begin
                #1;
                r0 = s_tready_o;
                m_tready_i = ~m_tready_i;
                #1;
                check("s_tready_comb", 32'(s_tready_o), 32'(r0));
                m_tready_i = ~m_tready_i;
            end
            @(negedge clk);
            hs = s_tvalid_i && s_tready_o;
            if (hs) acc_cyc_q.push_back(cyc);
            @(posedge clk); #1;
            if (hs) i++;
            budget++;
        end
        s_tvalid_i = 1'b0;
        start_i    = 1'b0;
        if (i < npix) check("drive_timeout", 32'(i), 32'(npix));
    endtask

    task automatic wait_done(input int d0, input bit toggle);
        int b = 0;
        while (done_cnt == d0 && b < 100) begin
            m_tready_i = toggle ? ~m_tready_i : 1'b1;
            @(posedge clk); #1;
            b++;
        end
        m_tready_i = 1'b1;
        check("frame_done_seen", 32'(done_cnt - d0), 32'd1);
        check("busy_after_done", 32'(busy_o), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("frame_done_once", 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic check_beats(input int w, input int npix, input int base);
        logic [9:0] exp;
        check("beat_count", 32'(beat_q.size()), 32'(npix));
        for (int k = 0; k < npix && k < beat_q.size(); k++) begin
            exp = {(k == 0), ((k % w) == w - 1), 8'(base + k)};
            check($sformatf("beat%0d", k), 32'(beat_q[k]), 32'(exp));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

    initial begin
        int d0;
        int e0;
        rst_n      = 1'b0;
        start_i    = 1'b0;
        width_i    = '0;
        height_i   = '0;
        s_tvalid_i = 1'b0;
        s_tdata_i  = '0;
        m_tready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 32'({m_tvalid_o, m_tuser_o, m_tlast_o, m_tdata_o, s_tready_o,
                                    busy_o, err_o, frame_done_o}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 4x2 frame, downstream always ready
        clear_q();
        d0 = done_cnt;
        do_start(4, 2);
        check("busy_on_start", 32'(busy_o), 32'd1);
        check("ready_on_start", 32'(s_tready_o), 32'd1);
        drive_pixels(8, 0, 1'b0, 1'b0, -1);
        wait_done(d0, 1'b0);
        check_beats(4, 8, 0);
        for (int k = 0; k < 8 && k < beat_cyc_q.size() && k < acc_cyc_q.size(); k++)
            check($sformatf("latency%0d", k), 32'(beat_cyc_q[k] - acc_cyc_q[k]), 32'd1);

        // Same frame with output backpressure and input gaps
        clear_q();
        d0 = done_cnt;
        do_start(4, 2);
        drive_pixels(8, 8'h10, 1'b1, 1'b1, -1);
        wait_done(d0, 1'b1);
        check_beats(4, 8, 8'h10);

        // 1x1 frame
        clear_q();
        d0 = done_cnt;
        do_start(1, 1);
        drive_pixels(1, 8'hA5, 1'b0, 1'b0, -1);
        wait_done(d0, 1'b0);
        check_beats(1, 1, 8'hA5);

        // Bad geometry
        e0 = err_cnt;
        do_start(0, 2);
        check("busy_bad_w", 32'(busy_o), 32'd0);
        do_start(4, MAX_H + 1);
        check("busy_bad_h", 32'(busy_o), 32'd0);
        check("ready_bad_h", 32'(s_tready_o), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("err_pulses", 32'(err_cnt - e0), 32'd2);
        check("busy_idle", 32'(busy_o), 32'd0);
        check("ready_idle", 32'(s_tready_o), 32'd0);

        // Start request mid-frame is ignored
        clear_q();
        d0 = done_cnt;
        e0 = err_cnt;
        do_start(4, 2);
        drive_pixels(8, 8'h20, 1'b0, 1'b0, 3);
        wait_done(d0, 1'b0);
        check_beats(4, 8, 8'h20);
        check("mid_start_no_err", 32'(err_cnt - e0), 32'd0);

        // Reset after pixel 5, then a fresh frame
        clear_q();
        d0 = done_cnt;
        do_start(4, 2);
        drive_pixels(6, 8'h30, 1'b0, 1'b0, -1);
        check("pre_reset_valid", 32'(m_tvalid_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_mid_outputs", 32'({m_tvalid_o, m_tuser_o, m_tlast_o, m_tdata_o, s_tready_o,
                                        busy_o, err_o, frame_done_o}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        repeat (2) @(posedge clk);
        #1;
        check("no_done_on_abort", 32'(done_cnt - d0), 32'd0);
        clear_q();
        d0 = done_cnt;
        do_start(4, 2);
        drive_pixels(8, 8'h40, 1'b0, 1'b0, -1);
        wait_done(d0, 1'b0);
        check_beats(4, 8, 8'h40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vid_framer.md
Name: vid_framer

Overview:
- Transmit-side counterpart to the streaming convolution input.
- Takes an unframed pixel stream and emits an AXI4-Stream video stream.
  - tuser marks start-of-frame (first pixel).
  - tlast marks end-of-line.
- Frame geometry is latched per frame from configuration inputs.
- Sits upstream of the convolution block; also used as the bench/source framer.

Parameters:
PIXEL_W, 8, pixel width in bits
MAX_W, 2048, maximum line width in pixels; COL_W = $clog2(MAX_W+1)
MAX_H, 2048, maximum frame height in lines; ROW_W = $clog2(MAX_H+1)

Ports:
clk_i  input  1  clock
rst_n  input  1  reset; one clock; reset is asynchronous and active-low
start_i  input  1  single-cycle frame start request
width_i  input  COL_W  pixels per line, sampled on accepted start
height_i  input  ROW_W  lines per frame, sampled on accepted start
busy_o  output  1  frame in progress
err_o  output  1  one-cycle pulse: start rejected for bad geometry
frame_done_o  output  1  one-cycle pulse: last pixel of frame handshaked on output
s_tvalid_i  input  1  unframed pixel valid
s_tdata_i  input  PIXEL_W  pixel data
s_tready_o  output  1  pixel accepted when high with s_tvalid_i
m_tvalid_o  output  1  output valid
m_tdata_o  output  PIXEL_W  output pixel
m_tuser_o  output  1  start-of-frame, first pixel only
m_tlast_o  output  1  end-of-line
m_tready_i  input  1  downstream ready

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; buffer empty.
- States:
  - IDLE: s_tready_o=0.
    - start_i with 1<=width_i<=MAX_W and 1<=height_i<=MAX_H: latch W,H; col=0, row=0; busy_o=1 next cycle; go to ACTIVE.
    - start_i with out-of-range geometry (zero or above max): err_o pulses next cycle; stay IDLE.
  - ACTIVE: accept pixels.
    - Per input handshake: tag tuser=(col==0&&row==0), tlast=(col==W-1).
    - col increments; on col==W-1, col wraps to 0 and row increments.
    - On the handshake of pixel (W-1,H-1): go to DRAIN; s_tready_o=0 from next cycle.
  - DRAIN: s_tready_o=0.
    - When the tagged last pixel handshakes on output: frame_done_o pulses next cycle; busy_o=0 next cycle; go to IDLE.
- start_i while busy_o=1: ignored; no err_o; no effect on latched W,H.
- start_i and the final output handshake in the same cycle: start ignored. A new frame needs busy_o=0.
- Output stage: 2-entry skid buffer.
  - Latency 1 cycle from input handshake to m_tvalid_o.
  - Sustained throughput 1 pixel/cycle with m_tready_i held high.
  - s_tready_o = (state==ACTIVE) && !skid_full.
  - s_tready_o is registered; no combinational path from m_tready_i.
- AXI rules:
  - Once m_tvalid_o=1, m_tdata_o/m_tuser_o/m_tlast_o stay stable until m_tready_i=1.
  - m_tvalid_o never drops without a handshake.
  - Pixel order is preserved.
- 1x1 frame: single beat with m_tuser_o=1 and m_tlast_o=1.
- W=1: every beat has tlast=1.
- H=1: only the first beat has tuser=1.
- Counters never exceed W-1 / H-1. Extra input pixels are not accepted outside ACTIVE and stay pending upstream.
- Async reset mid-frame: buffer flushed, m_tvalid_o=0 immediately, state IDLE. No frame_done_o is emitted for the aborted frame.

Test Plan:
- W=4,H=2, pixels 0..7, m_tready_i=1 -> 8 beats in order, 1 cycle after each accept. tuser on data 0 only; tlast on data 3 and 7. frame_done_o pulses once after data 7; busy_o then 0.
- Same frame with m_tready_i toggling 1010… and random s_tvalid_i gaps -> identical beat sequence. Outputs stable while stalled. No loss or duplication. s_tready_o never combinationally follows m_tready_i.
- W=1,H=1, pixel 0xA5 -> single beat with data 0xA5, tuser=1, tlast=1; frame_done_o pulse.
- start_i with width_i=0, then height_i=MAX_H+1 -> two err_o pulses; busy_o stays 0; s_tready_o stays 0.
- start_i asserted mid-frame with W=8 -> ignored. The frame completes with the original W=4 tlast pattern.
- rst_n low after pixel 5 of the 4x2 frame -> all outputs 0. A new 4x2 frame then restarts with tuser on its first pixel.
